// File: rtl/img2col_pkg.sv
// Shared definitions for the img2col weight path: field widths and the
// tile scheduler's state encoding.
package img2col_pkg;

    localparam int KSIZE_W = 3;
    localparam int VNUM_W  = 4;
    localparam int TILE_W  = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_GUARD = 3'd3,
        ST_WAIT  = 3'd4,
        ST_DONE  = 3'd5
    } sched_state_t;

endpackage

// File: rtl/img2col_wgt_sched.sv
// Tile scheduler for the img2col weight array: takes one layer config and
// walks its tiles through load, start, guard and wait-for-ready.
//
// state | meaning
// IDLE  | waiting for a config handshake; cfg_ready high
// LOAD  | tile_req high until the loader acks the current tile
// START | one-cycle i2c_wgt_start pulse
// GUARD | lane_ready ignored while the array settles after start
// WAIT  | waiting for every lane to report ready
// DONE  | one-cycle done pulse back to the sequencer
module img2col_wgt_sched
    import img2col_pkg::*;
#(
    parameter int SIZE      = 8,
    parameter int VALID_MAX = 8,
    parameter int GUARD     = 2
) (
    input  logic               clock,
    input  logic               rst_n,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [KSIZE_W-1:0] cfg_kernel,
    input  logic [TILE_W-1:0]  cfg_tiles,
    input  logic [VNUM_W-1:0]  cfg_last_valid,
    input  logic               abort,
    output logic               tile_req,
    input  logic               tile_ack,
    output logic [TILE_W-1:0]  tile_idx,
    output logic               i2c_wgt_start,
    output logic [KSIZE_W-1:0] kernel_size,
    output logic [VNUM_W-1:0]  valid_num,
    input  logic [SIZE-1:0]    lane_ready,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam logic [VNUM_W-1:0] VMAX   = VNUM_W'(VALID_MAX);
    localparam logic [2:0]        G_LAST = 3'(GUARD - 1);

    sched_state_t       state, state_nxt;
    logic [KSIZE_W-1:0] kernel_q;
    logic [TILE_W-1:0]  tiles_q;
    logic [VNUM_W-1:0]  last_valid_q;
    logic [TILE_W-1:0]  tile_idx_q;
    logic [VNUM_W-1:0]  valid_num_q;
    logic [2:0]         g_cnt;
    logic               err_q;

    logic              handshake;
    logic              cfg_bad;
    logic              last_tile;
    logic              all_ready;
    logic              advance;
    logic [TILE_W-1:0] idx_inc;

    // Abort in IDLE swallows a same-cycle config offer.
    assign handshake = cfg_valid && (state == ST_IDLE) && !abort;
    assign cfg_bad   = (cfg_kernel == '0) || (cfg_tiles == '0) || (cfg_last_valid == '0);
    assign last_tile = (tile_idx_q == tiles_q - 8'd1);
    assign all_ready = &lane_ready;
    assign idx_inc   = tile_idx_q + 8'd1;
    assign advance   = (state == ST_WAIT) && all_ready && !abort && !last_tile;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (handshake && !cfg_bad) state_nxt = ST_LOAD;
                ST_LOAD:  if (tile_ack) state_nxt = ST_START;
                ST_START: state_nxt = ST_GUARD;
                ST_GUARD: if (g_cnt == 3'd0) state_nxt = ST_WAIT;
                ST_WAIT:  if (all_ready) state_nxt = last_tile ? ST_DONE : ST_LOAD;
                ST_DONE:  state_nxt = ST_IDLE;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        cfg_ready     = 1'b0;
        tile_req      = 1'b0;
        i2c_wgt_start = 1'b0;
        done          = 1'b0;
        busy          = (state != ST_IDLE);
        case (state)
            ST_IDLE:  cfg_ready     = 1'b1;
            ST_LOAD:  tile_req      = 1'b1;
            ST_START: i2c_wgt_start = 1'b1;
            ST_DONE:  done          = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            kernel_q     <= '0;
            tiles_q      <= '0;
            last_valid_q <= '0;
            tile_idx_q   <= '0;
            valid_num_q  <= '0;
            g_cnt        <= '0;
            err_q        <= 1'b0;
        end else begin
            err_q <= handshake && cfg_bad;
            if (handshake) begin
                tile_idx_q <= '0;
            end
            // Illegal configs are rejected without disturbing the held layer settings.
            if (handshake && !cfg_bad) begin
                kernel_q     <= cfg_kernel;
                tiles_q      <= cfg_tiles;
                last_valid_q <= cfg_last_valid;
                valid_num_q  <= (cfg_tiles == 8'd1) ? cfg_last_valid : VMAX;
            end
            if (advance) begin
                tile_idx_q  <= idx_inc;
                valid_num_q <= (idx_inc == tiles_q - 8'd1) ? last_valid_q : VMAX;
            end
            if (state == ST_START) begin
                g_cnt <= G_LAST;
            end else if (state == ST_GUARD && g_cnt != 3'd0) begin
                g_cnt <= g_cnt - 3'd1;
            end
        end
    end

    assign tile_idx    = tile_idx_q;
    assign kernel_size = kernel_q;
    assign valid_num   = valid_num_q;
    assign err         = err_q;

endmodule

// File: tb/tb_img2col_wgt_sched.sv
// Directed bench for img2col_wgt_sched with a delayed-ack loader and a
// delayed-ready array model; expected values are worked out by hand.
module tb_img2col_wgt_sched;

    logic       clock;
    logic       rst_n;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [2:0] cfg_kernel;
    logic [7:0] cfg_tiles;
    logic [3:0] cfg_last_valid;
    logic       abort;
    logic       tile_req;
    logic       tile_ack;
    logic [7:0] tile_idx;
    logic       i2c_wgt_start;
    logic [2:0] kernel_size;
    logic [3:0] valid_num;
    logic [7:0] lane_ready;
    logic       busy;
    logic       done;
    logic       err;

    img2col_wgt_sched #(.SIZE(8), .VALID_MAX(8), .GUARD(2)) dut (
        .clock          (clock),
        .rst_n          (rst_n),
        .cfg_valid      (cfg_valid),
        .cfg_ready      (cfg_ready),
        .cfg_kernel     (cfg_kernel),
        .cfg_tiles      (cfg_tiles),
        .cfg_last_valid (cfg_last_valid),
        .abort          (abort),
        .tile_req       (tile_req),
        .tile_ack       (tile_ack),
        .tile_idx       (tile_idx),
        .i2c_wgt_start  (i2c_wgt_start),
        .kernel_size    (kernel_size),
        .valid_num      (valid_num),
        .lane_ready     (lane_ready),
        .busy           (busy),
        .done           (done),
        .err            (err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Event log written only by the monitor below.
    int cyc = 0, st_n = 0, done_n = 0, err_n = 0, req_n = 0, nrdy_n = 0, done_cyc = 0;
    int st_cyc [64];
    int st_vn  [64];
    int st_ti  [64];
    int st_ks  [64];

    int       ld_delay   = 4;
    int       arr_delay  = 10;
    bit       arr_manual = 0;
    logic [7:0] lane_mask = '0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    initial begin : monitor
        forever begin
            @(negedge clock);
            cyc++;
            if (i2c_wgt_start && st_n < 64) begin
                st_cyc[st_n] = cyc;
                st_vn[st_n]  = int'(valid_num);
                st_ti[st_n]  = int'(tile_idx);
                st_ks[st_n]  = int'(kernel_size);
                st_n++;
            end
            if (done) begin
                done_n++;
                done_cyc = cyc;
            end
            if (err)        err_n++;
            if (tile_req)   req_n++;
            if (!cfg_ready) nrdy_n++;
        end
    end

    initial begin : loader
        int cnt;
        cnt = 0;
        tile_ack = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            if (tile_req && !tile_ack) begin
                cnt++;
                if (cnt >= ld_delay) begin
                    tile_ack = 1'b1;
                    cnt = 0;
                end
            end else begin
                tile_ack = 1'b0;
                cnt = 0;
            end
        end
    end

    initial begin : array_model
        int cnt;
        cnt = 0;
        lane_ready = '0;
        forever begin
            @(posedge clock);
            #1;
            if (arr_manual) begin
                lane_ready = ~lane_mask;
            end else if (i2c_wgt_start) begin
                cnt = arr_delay;
                lane_ready = '0;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) lane_ready = '1;
            end
        end
    end

    task automatic send_cfg(input logic [2:0] k, input logic [7:0] t, input logic [3:0] lv);
        @(negedge clock);
        cfg_valid = 1'b1;
        cfg_kernel = k;
        cfg_tiles = t;
        cfg_last_valid = lv;
        @(negedge clock);
        cfg_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        for (int k = 0; k < budget; k++) begin
            @(negedge clock);
            #1;
            if (done) break;
        end
        check_eq({tag, "_done_seen"}, done, 1);
    endtask

    task automatic wait_start(input string tag, input int budget);
        for (int k = 0; k < budget; k++) begin
            @(negedge clock);
            if (i2c_wgt_start) break;
        end
        check_eq({tag, "_start_seen"}, i2c_wgt_start, 1);
    endtask

    initial begin : main
        int sb, db, eb, rb, nb;
        rst_n = 1'b0;
        cfg_valid = 1'b0;
        cfg_kernel = '0;
        cfg_tiles = '0;
        cfg_last_valid = '0;
        abort = 1'b0;
        #1;
        check_eq("rst_cfg_ready", cfg_ready, 1);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_tile_req", tile_req, 0);
        check_eq("rst_valid_num", valid_num, 0);
        check_eq("rst_kernel", kernel_size, 0);
        repeat (3) @(negedge clock);
        rst_n = 1'b1;

        // 1: three tiles, last_valid 5
        sb = st_n; db = done_n;
        send_cfg(3'd3, 8'd3, 4'd5);
        #1;
        check_eq("t1_req_latency", tile_req, 1);
        check_eq("t1_cfg_ready_low", cfg_ready, 0);
        wait_done("t1", 200);
        check_eq("t1_busy_at_done", busy, 1);
        check_eq("t1_starts", st_n - sb, 3);
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("t1_vn%0d", i), st_vn[sb+i], (i == 2) ? 5 : 8);
            check_eq($sformatf("t1_idx%0d", i), st_ti[sb+i], i);
            check_eq($sformatf("t1_ks%0d", i), st_ks[sb+i], 3);
        end
        check_eq("t1_gap01", st_cyc[sb+1] - st_cyc[sb], 15);
        check_eq("t1_gap12", st_cyc[sb+2] - st_cyc[sb+1], 15);
        check_eq("t1_done_lat", done_cyc - st_cyc[sb+2], 11);
        @(negedge clock);
        #1;
        check_eq("t1_busy_after", busy, 0);
        check_eq("t1_done_pulse", done, 0);
        check_eq("t1_done_count", done_n - db, 1);

        // 2: single tile uses last_valid
        sb = st_n;
        send_cfg(3'd2, 8'd1, 4'd3);
        wait_done("t2", 100);
        check_eq("t2_starts", st_n - sb, 1);
        check_eq("t2_vn", st_vn[sb], 3);
        check_eq("t2_ks", st_ks[sb], 2);
        check_eq("t2_done_lat", done_cyc - st_cyc[sb], 11);

        // 3: illegal configs
        @(negedge clock);
        #1;
        eb = err_n; rb = req_n; nb = nrdy_n;
        send_cfg(3'd3, 8'd0, 4'd5);
        #1;
        check_eq("t3_err_tiles0", err, 1);
        send_cfg(3'd0, 8'd2, 4'd5);
        #1;
        check_eq("t3_err_kernel0", err, 1);
        send_cfg(3'd3, 8'd2, 4'd0);
        #1;
        check_eq("t3_err_lv0", err, 1);
        repeat (3) @(negedge clock);
        #1;
        check_eq("t3_err_count", err_n - eb, 3);
        check_eq("t3_no_req", req_n - rb, 0);
        check_eq("t3_cfg_ready_held", nrdy_n - nb, 0);
        check_eq("t3_kernel_kept", kernel_size, 2);

        // 4: guard ignores ready; WAIT needs every lane
        arr_manual = 1'b1;
        lane_mask = '0;
        send_cfg(3'd4, 8'd1, 4'd6);
        wait_start("t4", 50);
        @(negedge clock);
        @(negedge clock);
        lane_mask = 8'h08;
        for (int j = 0; j < 6; j++) begin
            @(negedge clock);
            #1;
            check_eq($sformatf("t4_hold%0d", j), done, 0);
        end
        lane_mask = '0;
        @(negedge clock);
        #1;
        check_eq("t4_not_yet", done, 0);
        @(negedge clock);
        #1;
        check_eq("t4_done", done, 1);
        arr_manual = 1'b0;

        // 5: abort together with tile_ack of tile 1
        send_cfg(3'd6, 8'd4, 4'd2);
        for (int k = 0; k < 100; k++) begin
            @(negedge clock);
            if (tile_ack && tile_idx == 8'd1) break;
        end
        check_eq("t5_ack_tile1", (tile_ack && tile_idx == 8'd1), 1);
        #1;
        sb = st_n; db = done_n; eb = err_n;
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        #1;
        check_eq("t5_busy", busy, 0);
        check_eq("t5_req", tile_req, 0);
        check_eq("t5_cfg_ready", cfg_ready, 1);
        repeat (20) @(negedge clock);
        #1;
        check_eq("t5_no_start", st_n - sb, 0);
        check_eq("t5_no_done", done_n - db, 0);
        check_eq("t5_no_err", err_n - eb, 0);
        sb = st_n;
        send_cfg(3'd5, 8'd2, 4'd7);
        wait_done("t5b", 100);
        check_eq("t5b_starts", st_n - sb, 2);
        check_eq("t5b_vn0", st_vn[sb], 8);
        check_eq("t5b_vn1", st_vn[sb+1], 7);
        check_eq("t5b_idx1", st_ti[sb+1], 1);
        check_eq("t5b_ks", st_ks[sb+1], 5);

        // 6: reset during WAIT
        send_cfg(3'd3, 8'd3, 4'd5);
        wait_start("t6", 50);
        repeat (4) @(negedge clock);
        #1;
        check_eq("t6_in_wait", busy && !tile_req && !i2c_wgt_start, 1);
        rst_n = 1'b0;
        #1;
        check_eq("t6_busy", busy, 0);
        check_eq("t6_cfg_ready", cfg_ready, 1);
        check_eq("t6_tile_idx", tile_idx, 0);
        check_eq("t6_valid_num", valid_num, 0);
        check_eq("t6_kernel", kernel_size, 0);
        check_eq("t6_pulses", {i2c_wgt_start, done, err, tile_req}, 0);
        repeat (3) @(negedge clock);
        rst_n = 1'b1;
        sb = st_n;
        repeat (20) @(negedge clock);
        #1;
        check_eq("t6_no_restart", st_n - sb, 0);
        check_eq("t6_idle_after", {busy, cfg_ready}, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
